fios_result_collector: RTL and testbench
========================================

Name: fios_result_collector

Overview:
- Sits at the tail of the cascaded FIOS processing-element chain and consumes the per-cycle 17-bit result low words and 17-bit high parts emitted by the last PE.
- Resolves the redundant carries into canonical 17-bit words, applies the final Montgomery conditional subtraction of p, and presents the full-width reduced result on a valid/ready interface.
- This is the output-side counterpart of the PE chain's streaming word interface.

Parameters:
- NB_WORDS, 8: number of 17-bit words per operand/result; must be ≥ 2.
- WORD_W, 17: word width; fixed at 17 to match the DSP multiplier width.

Ports:
- clock_i  in  1  system clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- res_valid_i  in  1  result beat present on this cycle; the chain cannot stall.
- res_word_i  in  17  low result word of the current beat.
- res_carry_i  in  17  high part of the current beat, with weight 2^17 relative to res_word_i.
- res_last_i  in  1  marks the final beat (word NB_WORDS-1).
- p_word_i  in  17  modulus word aligned with the current beat, least-significant word first.
- result_o  out  17*NB_WORDS  reduced result; word 0 in bits [16:0].
- result_valid_o  out  1  result_o holds a complete result.
- result_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  collection or finalisation in progress.

Behaviour:
- Reset values:
  - result_o = 0, result_valid_o = 0, busy_o = 0.
  - State IDLE; word counter = 0; carry accumulator (18 bits) = 0; borrow = 0.
  - Reset mid-operation discards all partial data with no output.
- States: IDLE, COLLECT, FINAL, DONE.
- IDLE: on res_valid_i, process beat 0 and go to COLLECT. busy_o = 1 in COLLECT and FINAL.
- Per accepted beat k (counter = k):
  - sum = res_word_i + carry_acc, 19 bits.
  - word_k = sum[16:0].
  - carry_acc <= sum[18:17] + res_carry_i, held in 18 bits.
  - diff = word_k - p_word_i - borrow, 18 bits; diff_k = diff[16:0]; borrow <= diff[17].
  - word_k goes into the raw buffer and diff_k into the sub buffer, both at index k. The counter increments.
- Beat NB_WORDS-1 (counter = NB_WORDS-1):
  - Go to FINAL regardless of res_last_i.
  - If res_last_i is mismatched in either direction (missing here, or asserted earlier), raise a protocol error. An early res_last_i is otherwise ignored.
- FINAL, one cycle:
  - sel_sub = (carry_acc ≠ 0) or (borrow = 0).
  - Load result_o with the sub buffer if sel_sub is set, else the raw buffer.
  - Go to DONE with result_valid_o = 1.
- Latency: the edge accepting the last beat is E; result_valid_o is high after edge E+2.
- DONE:
  - Hold result_o and result_valid_o until result_valid_o & result_ready_i; then clear result_valid_o and return to IDLE.
  - A beat arriving in DONE while the handshake does not complete is dropped and flags overflow.
  - A beat arriving on the handshake cycle is dropped. The next result must start at least one cycle after the handshake.
- res_valid_i in FINAL is dropped and flags overflow.
- Arithmetic is modulo 2^(17·NB_WORDS) on the sub path. The input is < 2p, so a single subtraction suffices.

Optional Feature:
- Macro: FIOS_COLLECT_STATUS_EN.
- Defined:
  - Adds ports err_last_o (out, 1) and err_overflow_o (out, 1): sticky flags for the last-marker mismatch and for dropped beats.
  - Both are cleared only by reset_i.
- Undefined:
  - The ports are absent and no status registers exist.
  - Mismatched res_last_i and dropped beats are silently ignored; all other behaviour is identical.

Test Plan (NB_WORDS = 2):
- Below-p result: p words (0x00005, 0x00000); beats (0x00003, c0), (0x00000, c0 + last) -> result_o words (0x00003, 0x00000); valid two edges after the last beat.
- Reduction: p = 5; beats (0x00007, 0), (0x00000, 0, last) -> result words (0x00002, 0x00000).
- Carry resolution: p = 5; beats (0x1FFFF, carry 0x00001), (0x00000, 0, last) -> result words (0x1FFFA, 0x00001).
- Final carry out: p = 5; beats (0x00002, 0), (0x1FFFF, carry 0x00001, last) -> sel_sub forced; result words (0x1FFFD, 0x1FFFE).
- Backpressure: hold result_ready_i = 0 for 5 cycles after valid and inject a beat -> result_o stable, beat dropped, err_overflow_o = 1 with the macro defined; raise ready -> valid drops next cycle, state IDLE.
- Reset mid-collect: assert reset_i after beat 0 -> no result_valid_o; the next full sequence yields the correct result; missing res_last_i sets err_last_o = 1 (macro defined).

Source files
------------

// File: rtl/fios_result_collector.sv
// Tail of the FIOS PE chain: resolves redundant carries, applies the final conditional
// subtraction of p, and presents the reduced result. Optional status flags: FIOS_COLLECT_STATUS_EN.
module fios_result_collector #(
   parameter int NB_WORDS = 8,
   parameter int WORD_W   = 17
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         res_valid_i,
   input  logic [WORD_W-1:0]            res_word_i,
   input  logic [WORD_W-1:0]            res_carry_i,
   input  logic                         res_last_i,
   input  logic [WORD_W-1:0]            p_word_i,
   output logic [WORD_W*NB_WORDS-1:0]   result_o,
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic                         busy_o
`ifdef FIOS_COLLECT_STATUS_EN
   ,
   output logic                         err_last_o,
   output logic                         err_overflow_o
`endif
);

   localparam int                CNT_W     = $clog2(NB_WORDS);
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NB_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FINAL   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [WORD_W:0]      carry_acc;
   logic                 borrow;

   // Beats are registered once before being resolved, which sets the two-edge
   // gap between the last beat and result_valid_o.
   logic                 beat_valid;
   logic [WORD_W-1:0]    beat_word;
   logic [WORD_W-1:0]    beat_carry;
   logic                 beat_last;
   logic [WORD_W-1:0]    beat_p;

   logic [WORD_W-1:0]    raw_buf [NB_WORDS];
   logic [WORD_W-1:0]    sub_buf [NB_WORDS];

   logic                 handshake;
   logic                 accept;
   logic                 is_last_word;
   logic                 sel_sub;
   logic [WORD_W+1:0]    sum;
   logic [WORD_W:0]      acc_in;
   logic [WORD_W:0]      acc_next;
   logic [WORD_W:0]      diff;
   logic                 borrow_in;

   assign handshake    = result_valid_o & result_ready_i;
   assign accept       = beat_valid & ((state == IDLE) | (state == COLLECT));
   assign is_last_word = (cnt == LAST_WORD);
   assign sel_sub      = (carry_acc != '0) | ~borrow;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      acc_in    = carry_acc;
      borrow_in = borrow;
      if (state == IDLE) begin
         acc_in    = '0;
         borrow_in = 1'b0;
      end
      sum      = {2'b00, beat_word} + {1'b0, acc_in};
      acc_next = {{(WORD_W-1){1'b0}}, sum[WORD_W+1:WORD_W]} + {1'b0, beat_carry};
      diff     = {1'b0, sum[WORD_W-1:0]} - {1'b0, beat_p} - {{WORD_W{1'b0}}, borrow_in};
   end

   // NOTE: the word buffers carry no reset; they are always written before FINAL reads them.
   always_ff @(posedge clock_i) begin
      if (accept) begin
         raw_buf[cnt] <= sum[WORD_W-1:0];
         sub_buf[cnt] <= diff[WORD_W-1:0];
      end
      beat_word  <= res_word_i;
      beat_carry <= res_carry_i;
      beat_last  <= res_last_i;
      beat_p     <= p_word_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state          <= IDLE;
         cnt            <= '0;
         carry_acc      <= '0;
         borrow         <= 1'b0;
         beat_valid     <= 1'b0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         // A beat presented on the handshake cycle is discarded outright.
         beat_valid <= res_valid_i & ~handshake;
         case (state)
            IDLE, COLLECT: begin
               if (accept) begin
                  carry_acc <= acc_next;
                  borrow    <= diff[WORD_W];
                  busy_o    <= 1'b1;
                  if (is_last_word) begin
                     cnt   <= '0;
                     state <= FINAL;
                  end else begin
                     cnt   <= cnt + CNT_W'(1);
                     state <= COLLECT;
                  end
               end
            end
            FINAL: begin
               for (int i = 0; i < NB_WORDS; i++) begin
                  result_o[i*WORD_W +: WORD_W] <= sel_sub ? sub_buf[i] : raw_buf[i];
               end
               result_valid_o <= 1'b1;
               busy_o         <= 1'b0;
               state          <= DONE;
            end
            DONE: begin
               if (handshake) begin
                  result_valid_o <= 1'b0;
                  carry_acc      <= '0;
                  borrow         <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIOS_COLLECT_STATUS_EN
   logic last_err;
   logic drop;

   assign last_err = accept & (beat_last != is_last_word);
   assign drop     = beat_valid & ((state == FINAL) | (state == DONE));

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         err_last_o     <= 1'b0;
         err_overflow_o <= 1'b0;
      end else begin
         if (last_err) err_last_o     <= 1'b1;
         if (drop)     err_overflow_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fios_result_collector.sv
// Self-checking bench for fios_result_collector at NB_WORDS = 2: directed cases plus
// randomized values checked against an integer model of the Montgomery final subtraction.
module tb_fios_result_collector;

   localparam int NB = 2;
   localparam int W  = 17;

   logic              clock_i;
   logic              reset_i;
   logic              res_valid_i;
   logic [W-1:0]      res_word_i;
   logic [W-1:0]      res_carry_i;
   logic              res_last_i;
   logic [W-1:0]      p_word_i;
   logic [W*NB-1:0]   result_o;
   logic              result_valid_o;
   logic              result_ready_i;
   logic              busy_o;
`ifdef FIOS_COLLECT_STATUS_EN
   logic              err_last_o;
   logic              err_overflow_o;
`endif

   int checks = 0;
   int errors = 0;

   fios_result_collector #(.NB_WORDS(NB), .WORD_W(W)) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .res_valid_i    (res_valid_i),
      .res_word_i     (res_word_i),
      .res_carry_i    (res_carry_i),
      .res_last_i     (res_last_i),
      .p_word_i       (p_word_i),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .busy_o         (busy_o)
`ifdef FIOS_COLLECT_STATUS_EN
      ,
      .err_last_o     (err_last_o),
      .err_overflow_o (err_overflow_o)
`endif
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Value delivered by the chain is T; the reduced result is T - p when T >= p, else T,
   // taken modulo 2^(17*NB).
   function automatic logic [W*NB-1:0] model(input longint unsigned t, input longint unsigned p);
      if (t >= p) return (W*NB)'(t - p);
      return (W*NB)'(t);
   endfunction

   task automatic drive(input logic [W-1:0] w, input logic [W-1:0] c, input logic [W-1:0] p,
                        input logic last);
      @(negedge clock_i);
      res_valid_i = 1'b1;
      res_word_i  = w;
      res_carry_i = c;
      p_word_i    = p;
      res_last_i  = last;
   endtask

   task automatic idle_inputs();
      res_valid_i = 1'b0;
      res_last_i  = 1'b0;
      res_word_i  = '0;
      res_carry_i = '0;
      p_word_i    = '0;
   endtask

   // Two beats, then latency/result checks; handshake only when finish is set.
   task automatic send_pair(input string tag,
                            input logic [W-1:0] w0, input logic [W-1:0] c0, input logic [W-1:0] p0,
                            input logic [W-1:0] w1, input logic [W-1:0] c1, input logic [W-1:0] p1,
                            input logic last1, input logic [W*NB-1:0] exp, input logic finish);
      drive(w0, c0, p0, 1'b0);
      drive(w1, c1, p1, last1);
      @(negedge clock_i);
      idle_inputs();
      check({tag, "_valid_e1"}, 64'(result_valid_o), 64'd0);
      check({tag, "_busy_e1"}, 64'(busy_o), 64'd1);
      @(negedge clock_i);
      check({tag, "_valid_e2"}, 64'(result_valid_o), 64'd0);
      @(negedge clock_i);
      check({tag, "_valid_e3"}, 64'(result_valid_o), 64'd1);
      check({tag, "_result"}, 64'(result_o), 64'(exp));
      if (finish) begin
         result_ready_i = 1'b1;
         @(negedge clock_i);
         result_ready_i = 1'b0;
         check({tag, "_valid_after_hs"}, 64'(result_valid_o), 64'd0);
         check({tag, "_busy_after_hs"}, 64'(busy_o), 64'd0);
      end
   endtask

   initial begin
      longint unsigned p, t, r, rest, c0max;
      logic [W-1:0] w0, c0, w1, c1;

      reset_i        = 1'b1;
      result_ready_i = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clock_i);
      reset_i = 1'b0;
      @(negedge clock_i);
      check("reset_result", 64'(result_o), 64'd0);
      check("reset_valid", 64'(result_valid_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
`ifdef FIOS_COLLECT_STATUS_EN
      check("reset_err_last", 64'(err_last_o), 64'd0);
      check("reset_err_ovf", 64'(err_overflow_o), 64'd0);
`endif

      send_pair("below_p", 17'h00003, 17'h0, 17'h00005, 17'h00000, 17'h0, 17'h00000, 1'b1,
                {17'h00000, 17'h00003}, 1'b1);
      send_pair("reduction", 17'h00007, 17'h0, 17'h00005, 17'h00000, 17'h0, 17'h00000, 1'b1,
                {17'h00000, 17'h00002}, 1'b1);

      // Backpressure: result held for five cycles while a stray beat arrives.
      send_pair("bp", 17'h00007, 17'h0, 17'h00005, 17'h00000, 17'h0, 17'h00000, 1'b1,
                {17'h00000, 17'h00002}, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) drive(17'h1ABCD, 17'h00003, 17'h00005, 1'b0);
         else        @(negedge clock_i);
         if (i == 2) idle_inputs();
         check("bp_hold_result", 64'(result_o), 64'(34'h2));
         check("bp_hold_valid", 64'(result_valid_o), 64'd1);
      end
      idle_inputs();
`ifdef FIOS_COLLECT_STATUS_EN
      check("bp_err_ovf", 64'(err_overflow_o), 64'd1);
`endif
      // Handshake with a simultaneous beat: that beat must not start a new result.
      result_ready_i = 1'b1;
      res_valid_i    = 1'b1;
      res_word_i     = 17'h00011;
      @(negedge clock_i);
      result_ready_i = 1'b0;
      idle_inputs();
      check("bp_valid_drop", 64'(result_valid_o), 64'd0);
      check("bp_busy_idle", 64'(busy_o), 64'd0);
      repeat (2) @(negedge clock_i);
      check("hs_beat_dropped_busy", 64'(busy_o), 64'd0);
      check("hs_beat_dropped_valid", 64'(result_valid_o), 64'd0);

      send_pair("carry_res", 17'h1FFFF, 17'h00001, 17'h00005, 17'h00000, 17'h0, 17'h00000, 1'b1,
                {17'h00001, 17'h1FFFA}, 1'b1);
      send_pair("final_carry", 17'h00002, 17'h0, 17'h00005, 17'h1FFFF, 17'h00001, 17'h00000, 1'b1,
                {17'h1FFFE, 17'h1FFFD}, 1'b1);

      // Randomized: p in [2^33, 2^34), delivered value T < 2p split into redundant beats.
      for (int n = 0; n < 20; n++) begin
         p = 64'h2_0000_0000 | ({$urandom, $urandom} & 64'h1_FFFF_FFFF);
         t = {$urandom, $urandom} % (2 * p);
         c0max = t >> 17;
         if (c0max > 64'h1FFFF) c0max = 64'h1FFFF;
         c0   = W'($urandom_range(32'(c0max), 0));
         r    = t - (64'(c0) << 17);
         w0   = W'(r);
         rest = r >> 17;
         w1   = W'(rest);
         c1   = W'(rest >> 17);
         send_pair("random", w0, c0, W'(p), w1, c1, W'(p >> 17), 1'b1, model(t, p), 1'b1);
      end

      // Reset after beat 0 discards the partial result.
      drive(17'h1234, 17'h0, 17'h00005, 1'b0);
      @(negedge clock_i);
      idle_inputs();
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_result", 64'(result_o), 64'd0);
      repeat (3) @(negedge clock_i);
      check("midrst_no_valid", 64'(result_valid_o), 64'd0);
`ifdef FIOS_COLLECT_STATUS_EN
      check("midrst_err_ovf", 64'(err_overflow_o), 64'd0);
`endif
      send_pair("no_last", 17'h00007, 17'h0, 17'h00005, 17'h00000, 17'h0, 17'h00000, 1'b0,
                {17'h00000, 17'h00002}, 1'b1);
`ifdef FIOS_COLLECT_STATUS_EN
      check("no_last_err_last", 64'(err_last_o), 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
